// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU divider.
package mips_div_pkg;

    // Divider sequencing: idle/accept, one quotient bit per CALC cycle, sign fix-up.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

    localparam int DIV_WIDTH = 32;

    // Width of the step counter that counts WIDTH-1 down to 0.
    function automatic int div_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference if no borrow.
module mips_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dvd_bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // The trial value is one bit wider than the operands so a large partial
    // remainder shifted left is never truncated and the borrow is visible.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    assign trial   = {rem_i, dvd_bit_i};
    assign diff    = trial - {1'b0, divisor_i};
    assign q_bit_o = ~diff[WIDTH];
    assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/mips_divider.sv
// Iterative restoring divider producing LO (quotient) and HI (remainder) for
// MIPS DIV/DIVU. Latency is WIDTH+2 cycles from the start cycle to done.
// Optional build macro MIPS_DIVIDER_EARLY_ZERO_EN: a zero divisor returns its
// result one cycle after start without entering CALC/FIX.
//
// Handshake: start is sampled only while busy=0 (flush in the same cycle
// drops it); busy is high for the whole operation; done pulses for exactly
// one cycle, in which the DUT is already idle and may accept a new start.
// quotient/remainder hold their last result until the next one completes.
module mips_divider
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = div_cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes the raw quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
    logic [WIDTH-1:0] quo_q, quo_d;     // LO output register
    logic [WIDTH-1:0] remo_q, remo_d;   // HI output register
    logic             neg_a_q, neg_a_d; // dividend negative (signed op only)
    logic             neg_q_q, neg_q_d; // operand signs differ
    logic             zero_q, zero_d;   // divisor was zero
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             early_zero;
    logic             neg_a_in, neg_b_in;

`ifdef MIPS_DIVIDER_EARLY_ZERO_EN
    assign early_zero = (b == '0);
`else
    assign early_zero = 1'b0;
`endif

    assign neg_a_in = is_signed & a[WIDTH-1];
    assign neg_b_in = is_signed & b[WIDTH-1];

    mips_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dvs_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // Next-state and datapath updates for IDLE/CALC/FIX.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        remo_d  = remo_q;
        neg_a_d = neg_a_q;
        neg_q_d = neg_q_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (early_zero) begin
                        quo_d  = '1;
                        remo_d = a;
                        done_d = 1'b1;
                    end else begin
                        // The most negative value negates to itself, which
                        // read as unsigned is already its magnitude.
                        neg_a_d = neg_a_in;
                        neg_q_d = neg_a_in ^ neg_b_in;
                        zero_d  = (b == '0);
                        dvd_d   = neg_a_in ? (~a + 1'b1) : a;
                        dvs_d   = neg_b_in ? (~b + 1'b1) : b;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            FIX: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    // A zero divisor keeps the all-ones quotient unsigned; the
                    // remainder sign fix-up then restores the raw dividend.
                    quo_d   = (neg_q_q && !zero_q) ? (~dvd_q + 1'b1) : dvd_q;
                    remo_d  = neg_a_q ? (~rem_q + 1'b1) : rem_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            remo_q  <= '0;
            neg_a_q <= 1'b0;
            neg_q_q <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            remo_q  <= remo_d;
            neg_a_q <= neg_a_d;
            neg_q_q <= neg_q_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = remo_q;

endmodule

// File: tb/tb_mips_divider.sv
// Directed self-checking bench for mips_divider (WIDTH=32).
module tb_mips_divider;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        is_signed;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    localparam int LAT      = 34; // done cycle for a full operation
    localparam int BUSY_CYC = 33; // busy in cycles 1..33

    mips_divider dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive start for the current cycle (cycle 0); returns #1 into cycle 1.
    task automatic issue(input logic sgn, input logic [31:0] av, input logic [31:0] bv);
        start     = 1'b1;
        is_signed = sgn;
        a         = av;
        b         = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Watch one negedge per cycle until done, starting in cycle first_cyc.
    // Returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input int first_cyc,
                             input logic [31:0] eq, input logic [31:0] er,
                             input int elat, input int ebusy);
        int  cyc;
        int  busy_n;
        bit  seen;
        cyc    = first_cyc;
        busy_n = 0;
        seen   = 0;
        while (!seen && cyc < 120) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_n++;
                cyc++;
            end
        end
        check_eq({tag, " done_cycle"}, cyc, elat);
        check_eq({tag, " busy_cycles"}, busy_n, ebusy);
        check_eq({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({tag, " quotient"}, quotient, eq);
        check_eq({tag, " remainder"}, remainder, er);
    endtask

    // Full operation starting in the next cycle.
    task automatic run_op(input string tag, input logic sgn,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eq, input logic [31:0] er);
        @(posedge clk);
        #1;
        issue(sgn, av, bv);
        wait_done(tag, 1, eq, er, LAT, BUSY_CYC);
    endtask

    initial begin
        int dones;
        reset_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        flush     = 1'b0;
        a         = '0;
        b         = '0;

        #2;
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst done", {31'd0, done}, 32'd0);
        check_eq("rst quotient", quotient, 32'd0);
        check_eq("rst remainder", remainder, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Unsigned and signed basics.
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_op("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE);
        run_op("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3);
        run_op("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        run_op("divu_ffff_13", 1'b0, 32'hFFFF_FFFF, 32'd13, 32'h13B1_3B13, 32'd8);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);

        // Divide by zero.
        @(posedge clk);
        #1;
        issue(1'b0, 32'd5, 32'd0);
`ifdef MIPS_DIVIDER_EARLY_ZERO_EN
        wait_done("divu_5_0", 1, 32'hFFFF_FFFF, 32'd5, 1, 0);
`else
        wait_done("divu_5_0", 1, 32'hFFFF_FFFF, 32'd5, LAT, BUSY_CYC);
`endif
        @(posedge clk);
        #1;
        issue(1'b1, 32'hFFFF_FFFB, 32'd0);
`ifdef MIPS_DIVIDER_EARLY_ZERO_EN
        wait_done("div_m5_0", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0);
`else
        wait_done("div_m5_0", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT, BUSY_CYC);
`endif

        // Start during cycle 5 of a busy operation is ignored.
        @(posedge clk);
        #1;
        issue(1'b0, 32'd100, 32'd7);          // now in cycle 1
        repeat (4) @(posedge clk);            // cycle 5
        #1;
        issue(1'b0, 32'd9, 32'd3);            // now in cycle 6
        wait_done("ignored_start", 6, 32'd14, 32'd2, LAT, BUSY_CYC - 5);

        // Flush in cycle 10: busy drops in cycle 11, no done, outputs held.
        @(posedge clk);
        #1;
        issue(1'b0, 32'd50, 32'd3);           // cycle 1
        repeat (9) @(posedge clk);            // cycle 10
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;                          // cycle 11
        @(negedge clk);
        check_eq("flush busy_c11", {31'd0, busy}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("flush no_done", dones, 0);
        check_eq("flush quotient_held", quotient, 32'd14);
        check_eq("flush remainder_held", remainder, 32'd2);

        // Flush beats start in the same idle cycle.
        @(posedge clk);
        #1;
        flush = 1'b1;
        issue(1'b0, 32'd50, 32'd3);
        flush = 1'b0;
        @(negedge clk);
        check_eq("flush_vs_start busy", {31'd0, busy}, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("flush_vs_start no_done", dones, 0);

        // Asynchronous reset mid-CALC clears outputs immediately.
        @(posedge clk);
        #1;
        issue(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst busy", {31'd0, busy}, 32'd0);
        check_eq("async_rst done", {31'd0, done}, 32'd0);
        check_eq("async_rst quotient", quotient, 32'd0);
        check_eq("async_rst remainder", remainder, 32'd0);
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("async_rst no_done", dones, 0);
        @(posedge clk);
        #3 reset_n = 1'b1;

        // Back-to-back: start 1/1 in the done cycle of 100/7.
        run_op("b2b_first", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        issue(1'b0, 32'd1, 32'd1);
        wait_done("b2b_second", 1, 32'd1, 32'd0, LAT, BUSY_CYC);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
